// File: rtl/mul_ctrl_if.sv
// Request, datapath and result bundle for the RV64M multiply controller.
// The slave side is the controller; the master side is the requester/datapath.
interface mul_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_word;
  logic [63:0]      in_rs1;
  logic [63:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic [65:0]      dp_a;
  logic [65:0]      dp_b;
  logic [127:0]     dp_sum;
  logic [127:0]     dp_carry;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  in_valid, in_op, in_word,
    input  in_rs1, in_rs2, in_tag,
    input  flush, dp_sum, dp_carry,
    input  out_ready,
    output in_ready, dp_a, dp_b,
    output out_valid, out_result,
    output out_tag, busy
  );

  modport master (
    output in_valid, in_op, in_word,
    output in_rs1, in_rs2, in_tag,
    output flush, dp_sum, dp_carry,
    output out_ready,
    input  in_ready, dp_a, dp_b,
    input  out_valid, out_result,
    input  out_tag, busy
  );
endinterface

// File: rtl/mul_ctrl.sv
// RV64M multiplier issue/sequencing controller: operand extension,
// tree capture, final carry-propagate add and tagged result return.
module mul_ctrl #(
  parameter int TAG_W = 5
) (
  input logic     clk,
  input logic     rst,
  mul_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    CLS_LO,
    CLS_HI,
    CLS_W
  } cls_e;

  logic             s1_valid;
  cls_e             s1_cls;
  logic [TAG_W-1:0] s1_tag;
  logic [65:0]      dp_a;
  logic [65:0]      dp_b;

  logic             s2_valid;
  cls_e             s2_cls;
  logic [TAG_W-1:0] s2_tag;
  logic [127:0]     s2_sum;
  logic [127:0]     s2_carry;

  logic             out_valid;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  logic adv1;
  logic adv2;
  logic adv3;
  logic in_ready;
  logic accept;

  assign adv3     = !out_valid || bus.out_ready;
  assign adv2     = !s2_valid || adv3;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !bus.flush && !rst;
  assign accept   = bus.in_valid && in_ready;

  cls_e        dec_cls;
  logic        sx1;
  logic        sx2;
  logic [65:0] ext_a;
  logic [65:0] ext_b;

  always_comb begin
    dec_cls = CLS_LO;
    sx1     = 1'b1;
    sx2     = 1'b1;
    unique case (1'b1)
      bus.in_word: begin
        dec_cls = CLS_W;
      end
      !bus.in_word && bus.in_op == 3'b001: begin
        dec_cls = CLS_HI;
      end
      !bus.in_word && bus.in_op == 3'b010: begin
        dec_cls = CLS_HI;
        sx2     = 1'b0;
      end
      !bus.in_word && bus.in_op == 3'b011: begin
        dec_cls = CLS_HI;
        sx1     = 1'b0;
        sx2     = 1'b0;
      end
      default: begin
        dec_cls = CLS_LO;
      end
    endcase
    if (bus.in_word) begin
      ext_a = {{34{bus.in_rs1[31]}}, bus.in_rs1[31:0]};
      ext_b = {{34{bus.in_rs2[31]}}, bus.in_rs2[31:0]};
    end else begin
      ext_a = {{2{sx1 & bus.in_rs1[63]}}, bus.in_rs1};
      ext_b = {{2{sx2 & bus.in_rs2[63]}}, bus.in_rs2};
    end
  end

  logic [127:0] prod;
  logic [63:0]  sel;

  always_comb begin
    prod = s2_sum + s2_carry;
    case (s2_cls)
      CLS_HI:  sel = prod[127:64];
      CLS_W:   sel = {{32{prod[31]}}, prod[31:0]};
      default: sel = prod[63:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          dp_a   <= ext_a;
          dp_b   <= ext_b;
          s1_cls <= dec_cls;
          s1_tag <= bus.in_tag;
        end
      end
      // the tree output is only meaningful while S1 holds a valid op
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum   <= bus.dp_sum;
          s2_carry <= bus.dp_carry;
          s2_cls   <= s1_cls;
          s2_tag   <= s1_tag;
        end
      end
      if (adv3) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_result <= sel;
          out_tag    <= s2_tag;
        end
      end
      if (bus.flush) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.dp_a       = dp_a;
  assign bus.dp_b       = dp_b;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_result;
  assign bus.out_tag    = out_tag;
  assign bus.busy       = s1_valid | s2_valid | out_valid;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural Booth/Wallace tree
// that splits each product into an arbitrary sum/carry pair.
module tb_mul_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_ctrl_if #(.TAG_W(5)) bus ();

  mul_ctrl #(.TAG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [127:0] CK =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic [127:0] a128;
  logic [127:0] b128;
  logic [127:0] p128;

  always_comb begin
    a128 = {{62{bus.dp_a[65]}}, bus.dp_a};
    b128 = {{62{bus.dp_b[65]}}, bus.dp_b};
    p128 = a128 * b128;
    bus.dp_carry = CK;
    bus.dp_sum = p128 - CK;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [63:0] got_res[$];
  logic [4:0]  got_tag[$];
  int          got_cyc[$];

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_res.push_back(bus.out_result);
      got_tag.push_back(bus.out_tag);
      got_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_q;
    got_res.delete();
    got_tag.delete();
    got_cyc.delete();
  endtask

  task automatic idle;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic put(input logic [2:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] t);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_word = w;
    bus.in_rs1 = a;
    bus.in_rs2 = b;
    bus.in_tag = t;
  endtask

  task automatic wait_res(input int n);
    int k;
    k = 0;
    while (got_res.size() < n && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    put(3'b000, 1'b0, 64'd1, 64'd1, 5'd0);
    step();
    step();
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready got=%b want=0", bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid ov=%b busy=%b want=0",
               bus.out_valid, bus.busy);
    end
    total++;
    if (bus.dp_a !== 66'd0 || bus.out_result !== 64'd0) begin
      bad++;
      $display("FAIL rst_zero dp_a=%h res=%h want=0",
               bus.dp_a, bus.out_result);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_ready got=%b want=1", bus.in_ready);
    end
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_mul;
    int start;
    bus.out_ready = 1'b1;
    put(3'b000, 1'b0, 64'd3, 64'd5, 5'd7);
    start = cyc;
    step();
    idle();
    total++;
    if (bus.dp_a !== 66'd3 || bus.dp_b !== 66'd5) begin
      bad++;
      $display("FAIL mul_dp a=%h b=%h want=3,5", bus.dp_a, bus.dp_b);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mul_early got=%b want=0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 64'hF ||
        bus.out_tag !== 5'd7) begin
      bad++;
      $display("FAIL mul_out v=%b r=%h t=%0d want=1,f,7",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    step();
    total++;
    if (got_res.size() != 1 || got_cyc[0] != start + 3) begin
      bad++;
      $display("FAIL mul_latency n=%0d want=1 at +3",
               got_res.size());
    end
    clear_q();
  endtask

  task automatic test_back_to_back;
    int start;
    logic [63:0] ex[3];
    ex[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    ex[1] = 64'h0;
    ex[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.out_ready = 1'b1;
    start = cyc;
    put(3'b011, 1'b0, '1, '1, 5'd1);
    step();
    total++;
    if (bus.dp_a !== 66'h0_FFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL mulhu_ext got=%h", bus.dp_a);
    end
    put(3'b001, 1'b0, '1, '1, 5'd2);
    step();
    total++;
    if (bus.dp_a !== 66'h3_FFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL mulh_ext got=%h", bus.dp_a);
    end
    put(3'b010, 1'b0, '1, 64'd2, 5'd3);
    step();
    idle();
    wait_res(3);
    total++;
    if (got_res.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=3", got_res.size());
      clear_q();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_res[i] !== ex[i] || got_tag[i] !== 5'(i + 1) ||
          got_cyc[i] != start + 3 + i) begin
        bad++;
        $display("FAIL b2b_%0d r=%h t=%0d c=%0d want=%h,%0d,%0d",
                 i, got_res[i], got_tag[i], got_cyc[i] - start,
                 ex[i], i + 1, 3 + i);
      end
    end
    clear_q();
  endtask

  task automatic test_mulw;
    logic [63:0] ex[2];
    ex[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    ex[1] = 64'hFFFF_FFFF_8000_0000;
    bus.out_ready = 1'b1;
    put(3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd4);
    step();
    put(3'b000, 1'b1, 64'hFFFF_FFFF_8000_0000, '1, 5'd5);
    step();
    idle();
    wait_res(2);
    total++;
    if (got_res.size() != 2) begin
      bad++;
      $display("FAIL mulw_count got=%0d want=2", got_res.size());
      clear_q();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got_res[i] !== ex[i]) begin
        bad++;
        $display("FAIL mulw_%0d got=%h want=%h", i, got_res[i], ex[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_backpressure;
    logic exp_rdy;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(3'b000, 1'b0, 64'(i + 1), 64'd10, 5'(i + 1));
      #1;
      exp_rdy = (i < 3);
      total++;
      if (bus.in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL bp_ready_%0d got=%b want=%b",
                 i, bus.in_ready, exp_rdy);
      end
      if (i < 3) step();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd10 ||
          bus.out_tag !== 5'd1 || bus.in_ready !== 1'b0 ||
          bus.dp_a !== 66'd3) begin
        bad++;
        $display("FAIL bp_hold_%0d v=%b r=%h t=%0d rdy=%b a=%h",
                 k, bus.out_valid, bus.out_result, bus.out_tag,
                 bus.in_ready, bus.dp_a);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b want=1", bus.in_ready);
    end
    step();
    idle();
    wait_res(4);
    step();
    step();
    total++;
    if (got_res.size() != 4) begin
      bad++;
      $display("FAIL bp_count got=%0d want=4", got_res.size());
      clear_q();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_res[i] !== 64'((i + 1) * 10) ||
          got_tag[i] !== 5'(i + 1)) begin
        bad++;
        $display("FAIL bp_res_%0d r=%h t=%0d want=%0d,%0d",
                 i, got_res[i], got_tag[i], (i + 1) * 10, i + 1);
      end
    end
    clear_q();
  endtask

  task automatic test_flush;
    int start;
    bus.out_ready = 1'b1;
    put(3'b000, 1'b0, 64'd2, 64'd2, 5'd8);
    step();
    put(3'b000, 1'b0, 64'd3, 64'd3, 5'd9);
    step();
    put(3'b000, 1'b0, 64'd4, 64'd4, 5'd10);
    bus.flush = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%b want=0", bus.in_ready);
    end
    step();
    idle();
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear busy=%b ov=%b want=0",
               bus.busy, bus.out_valid);
    end
    for (int k = 0; k < 5; k++) step();
    total++;
    if (got_res.size() != 0) begin
      bad++;
      $display("FAIL flush_leak got=%0d want=0", got_res.size());
    end
    clear_q();
    start = cyc;
    put(3'b000, 1'b0, 64'd6, 64'd7, 5'd11);
    step();
    idle();
    wait_res(1);
    total++;
    if (got_res.size() != 1 || got_res[0] !== 64'h2A ||
        got_tag[0] !== 5'd11 || got_cyc[0] != start + 3) begin
      bad++;
      $display("FAIL flush_after n=%0d want=2a tag 11 at +3",
               got_res.size());
    end
    clear_q();
  endtask

  task automatic test_reset_inflight;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(3'b000, 1'b0, 64'(i + 5), 64'd3, 5'(i + 20));
      step();
    end
    idle();
    rst = 1'b1;
    step();
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b0 || bus.out_result !== 64'd0 ||
        bus.out_tag !== 5'd0 || bus.dp_a !== 66'd0) begin
      bad++;
      $display("FAIL rst_flight ov=%b busy=%b rdy=%b r=%h t=%0d",
               bus.out_valid, bus.busy, bus.in_ready,
               bus.out_result, bus.out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    total++;
    if (got_res.size() != 0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_stale n=%0d ov=%b want=0",
               got_res.size(), bus.out_valid);
    end
    clear_q();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.in_op = 3'b000;
    bus.in_word = 1'b0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_back_to_back();
    test_mulw();
    test_backpressure();
    test_flush();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Issue/sequencing controller for the RV64M multiplier. It decodes MUL/MULH/MULHSU/MULHU/MULW requests and sign- or zero-extends the operands to 66 bits for the Booth/Wallace datapath. It captures the 128-bit sum/carry pair from the tree, performs the final carry-propagate add and result selection, and returns tagged results. The pipeline is 3 stages, fully pipelined, with valid/ready on both sides and a pipeline flush.

## Interface
Parameters:
- TAG_W, 5, width of the request tag carried alongside each operation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other values treated as MUL
- in_word  in  1  MULW: only op 000 is legal; any op with in_word=1 executes as MULW
- in_rs1, in_rs2  in  64  operands
- in_tag  in  TAG_W  request tag
- flush  in  1  kill all in-flight operations
- dp_a, dp_b  out  66  registered extended operands driven to the Booth/Wallace datapath
- dp_sum, dp_carry  in  128  combinational tree outputs for dp_a*dp_b; the product mod 2^128 is dp_sum+dp_carry
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_result  out  64  result
- out_tag  out  TAG_W  tag of result
- busy  out  1  any stage valid

## Operation
- Stages:
  - S1 holds dp_a/dp_b, op class, word flag and tag.
  - S2 registers dp_sum/dp_carry plus op class and tag.
  - S3 is the output register.
- Operand extension to 66 bits:
  - MUL: both operands sign-extended.
  - MULH: both sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both zero-extended.
  - MULW: rs1[31:0] and rs2[31:0] sign-extended to 66 bits.
- S3 computes P = (dp_sum + dp_carry) mod 2^128 from the S2 registers and selects the result:
  - MUL: P[63:0].
  - MULH/MULHSU/MULHU: P[127:64].
  - MULW: {32{P[31]}, P[31:0]}.
- Pipeline advance:
  - adv3 = !out_valid || out_ready.
  - adv2 = !s2_valid || adv3.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 && !flush && !rst.
  - Bubbles collapse: a stage loads whenever it is empty or its contents move forward.
- A stage that advances without new input becomes invalid. Its data registers may hold stale values; only valid bits are significant.
- Held stages keep all registers constant: dp_a and dp_b stay stable while S1 is stalled.
- Flush: in the cycle flush=1, the next edge clears s1_valid, s2_valid and out_valid. The request offered in that cycle is not accepted. flush has priority over out_ready and in_valid.
- A result presented with out_valid && out_ready in the flush cycle counts as consumed. After the edge, out_valid is 0.
- Reset clears all valid bits and zeroes dp_a, dp_b, out_result and out_tag. Reset mid-operation drops everything in flight; no partial result is emitted.
- busy = s1_valid | s2_valid | out_valid.
- Results leave in acceptance order. No reordering.

## Timing
- Request accepted in cycle c: dp_a/dp_b are valid in cycle c+1, and the tree output is sampled at the end of c+1. out_valid=1 with the result in cycle c+3, provided no stall.
- Throughput is one operation per cycle with out_ready held high.
- While out_valid && !out_ready, out_result and out_tag hold stable. Upstream stages keep filling until full; with 3 operations in flight, in_ready=0 combinationally in that same cycle.
- The consumer raising out_ready re-enables in_ready in the same cycle (combinational ready chain).
- During rst=1: in_ready=0, out_valid=0, busy=0. In the first cycle after rst falls, in_ready=1.
- The dp_sum/dp_carry path is combinational from dp_a/dp_b and must settle within one cycle. The block adds no multicycle path.

## Test plan
- MUL rs1=3, rs2=5, tag=7, out_ready=1 → out_valid in cycle c+3, out_result=0x000000000000000F, out_tag=7.
- Back-to-back, one request per cycle:
  - MULHU 0xFFFFFFFFFFFFFFFF×0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE.
  - MULH same operands → 0x0000000000000000.
  - MULHSU rs1=0xFFFFFFFFFFFFFFFF, rs2=2 → 0xFFFFFFFFFFFFFFFF.
  - Results on 3 consecutive cycles, in order.
- MULW rs1=0x123456787FFFFFFF, rs2=0x0000000000000002 → 0xFFFFFFFFFFFFFFFE. MULW rs1=0xFFFFFFFF80000000, rs2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFF80000000.
- Backpressure:
  - Hold out_ready=0 and issue 4 requests: 3 are accepted and in_ready=0 while the 4th is pending.
  - out_result stays stable throughout the stall.
  - Raise out_ready: all 4 results are delivered in order with no loss or duplication.
- Flush:
  - Issue 2 requests, then assert flush in cycle c+2: no out_valid follows, busy=0 next cycle, and a request offered during the flush cycle is not accepted.
  - A MUL 6×7 issued after the flush returns 0x2A at +3.
- Assert rst with 3 operations in flight (out_ready=0) → outputs, valids and busy are 0 the next cycle and no stale result appears after rst deasserts.
